// File: rtl/fifo_word_reader.sv
// fifo_word_reader
//
// Pops bytes from an 8-entry x 8-bit FIFO and packs them little-endian into 32-bit words,
// presented on a valid/ready stream with per-byte keep flags. A flush request emits the
// current partial word so trailing bytes are never stranded.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   fifo_empty - FIFO empty flag
//   fifo_rd    - FIFO read strobe (combinational, never high while fifo_empty)
//   fifo_dout  - FIFO read data, valid the cycle after fifo_rd
//   flush      - single-cycle request to emit the current partial word
//   m_data     - packed word, first byte popped in [7:0]
//   m_keep     - lane-valid flags, bit k set when lane k holds a real byte
//   m_valid    - output word valid
//   m_ready    - downstream accepts word
//   busy       - any byte captured, in flight, held, or flush pending

module fifo_word_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_dout,
    input  logic        flush,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy
);

    typedef enum logic [0:0] {StFill, StOut} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rd_pend_q;
    logic        flush_req_q, flush_req_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  keep_q, keep_d;
    logic        valid_q, valid_d;
    logic        flush_clr;
    logic [2:0]  level;

    // Bytes captured plus the one in flight; reads stop once a full word is accounted for.
    assign level = cnt_q + {2'b00, rd_pend_q};

    assign fifo_rd = !rst && (state_q == StFill) && !fifo_empty && !flush_req_q &&
                     (level < 3'd4);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        keep_d    = keep_q;
        valid_d   = valid_q;
        flush_clr = 1'b0;

        case (state_q)
            StFill: begin
                if (rd_pend_q) begin
                    data_d[{cnt_q[1:0], 3'b000} +: 8] = fifo_dout;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        state_d = StOut;
                        valid_d = 1'b1;
                        keep_d  = 4'b1111;
                    end
                end else if (flush_req_q) begin
                    // Flush only acts once no byte is in flight, so the partial word is final.
                    if (cnt_q != 3'd0) begin
                        state_d = StOut;
                        valid_d = 1'b1;
                        case (cnt_q)
                            3'd1:    keep_d = 4'b0001;
                            3'd2:    keep_d = 4'b0011;
                            default: keep_d = 4'b0111;
                        endcase
                    end else begin
                        flush_clr = 1'b1;
                    end
                end
            end
            StOut: begin
                // A flush latched while holding a word is absorbed by its handshake.
                if (valid_q && m_ready) begin
                    state_d   = StFill;
                    cnt_d     = 3'd0;
                    data_d    = 32'h0;
                    keep_d    = 4'h0;
                    valid_d   = 1'b0;
                    flush_clr = 1'b1;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    assign flush_req_d = flush_clr ? 1'b0 : (flush_req_q | flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            cnt_q       <= 3'd0;
            rd_pend_q   <= 1'b0;
            flush_req_q <= 1'b0;
            data_q      <= 32'h0;
            keep_q      <= 4'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= fifo_rd;
            flush_req_q <= flush_req_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            valid_q     <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_valid = valid_q;
    assign busy    = (cnt_q != 3'd0) | rd_pend_q | valid_q | flush_req_q;

endmodule
